// File: rtl/nexi_intc_pkg.sv
// rtl/nexi_intc_pkg.sv - shared constants for the nexi_intc_wb interrupt controller
package nexi_intc_pkg;

  // Largest source count that fits the 68k autovector levels 1..7
  localparam int MAX_SRC = 7;

  // Width of the encoded interrupt priority level sent to the CPU
  localparam int IPL_W = 3;

  // Register selects, taken from addr_i[4:2]
  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_PENDING = 3'd1;
  localparam logic [2:0] REG_ENABLE  = 3'd2;
  localparam logic [2:0] REG_MODE    = 3'd3;
  localparam logic [2:0] REG_SOFT    = 3'd4;

endpackage

// File: rtl/nexi_sync2.sv
// rtl/nexi_sync2.sv - parameterised-width two-flop synchronizer
module nexi_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First flop may go metastable; the second gives it a full cycle to settle
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nexi_intc_wb.sv
// rtl/nexi_intc_wb.sv - Wishbone interrupt controller driving the 68k IPL; optional NEXI_INTC_SOFT_IRQ_EN
module nexi_intc_wb
  import nexi_intc_pkg::*;
#(
  parameter int         NUM_SRC    = 7,
  parameter logic [6:0] RESET_MODE = 7'h00
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cyc_i,
  input  logic               stb_i,
  input  logic               we_i,
  input  logic [4:0]         addr_i,
  input  logic [31:0]        data_i,
  input  logic [3:0]         sel_i,
  output logic [31:0]        data_o,
  output logic               ack_o,
  input  logic [NUM_SRC-1:0] irq_i,
  output logic [IPL_W-1:0]   ipl_o
);

  logic [NUM_SRC-1:0] s_irq;
  logic [NUM_SRC-1:0] s_irq_d;
  logic [NUM_SRC-1:0] irq_rise;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] pending_nxt;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] mode;
  logic [NUM_SRC-1:0] pend_en;
  logic [NUM_SRC-1:0] w1c_mask;
  logic [NUM_SRC-1:0] soft_mask;
  logic [NUM_SRC-1:0] wr_bits;
  logic [IPL_W-1:0]   ipl_q;
  logic [IPL_W-1:0]   ipl_nxt;
  logic               ack_q;
  logic [31:0]        data_q;
  logic [31:0]        rdata;
  logic               access;
  logic               wr_en;
  logic [2:0]         reg_sel;
  logic               unused_bits;

  assign ack_o  = ack_q;
  assign data_o = data_q;
  assign ipl_o  = ipl_q;

  // Only byte lane 0 carries register data; the rest of the bus is ignored
  assign unused_bits = ^{addr_i[1:0], sel_i[3:1], data_i[31:NUM_SRC]};

  // A new access is accepted only while ack is low, so every access costs two cycles
  assign access  = cyc_i & stb_i & ~ack_q;
  assign wr_en   = access & we_i & sel_i[0];
  assign reg_sel = addr_i[4:2];
  assign wr_bits = data_i[NUM_SRC-1:0];

  nexi_sync2 #(
    .WIDTH (NUM_SRC)
  ) u_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   (irq_i),
    .q   (s_irq)
  );

  assign irq_rise = s_irq & ~s_irq_d;
  assign pend_en  = pending & enable;
  assign w1c_mask = (wr_en && reg_sel == REG_PENDING) ? wr_bits : '0;

`ifdef NEXI_INTC_SOFT_IRQ_EN
  assign soft_mask = (wr_en && reg_sel == REG_SOFT) ? wr_bits : '0;
`else
  assign soft_mask = '0;
`endif

  // Edge bits hold until cleared (a same-cycle set beats the clear); level bits follow s_irq
  always_comb begin
    pending_nxt = (mode & ((pending & ~w1c_mask) | irq_rise))
                | (~mode & s_irq)
                | soft_mask;
  end

  // Highest enabled pending source wins; source k becomes level k+1
  always_comb begin
    ipl_nxt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pend_en[i]) begin
        ipl_nxt = IPL_W'(i + 1);
      end
    end
  end

  // Read mux; unmapped offsets and SOFT read as zero
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_STATUS: begin
        rdata[NUM_SRC-1:0] = pend_en;
        rdata[8 +: IPL_W]  = ipl_q;
      end
      REG_PENDING: rdata[NUM_SRC-1:0] = pending;
      REG_ENABLE:  rdata[NUM_SRC-1:0] = enable;
      REG_MODE:    rdata[NUM_SRC-1:0] = mode;
      default:     rdata = '0;
    endcase
  end

  // Bus handshake: one-cycle ack with read data captured on the same edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q  <= 1'b0;
      data_q <= '0;
    end else begin
      ack_q  <= access;
      data_q <= access ? rdata : '0;
    end
  end

  // Configuration registers commit on the edge that raises ack
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable <= '0;
      mode   <= RESET_MODE[NUM_SRC-1:0];
    end else begin
      if (wr_en && reg_sel == REG_ENABLE) begin
        enable <= wr_bits;
      end
      if (wr_en && reg_sel == REG_MODE) begin
        mode <= wr_bits;
      end
    end
  end

  // Pending state, edge-detect history and the registered priority level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_irq_d <= '0;
      pending <= '0;
      ipl_q   <= '0;
    end else begin
      s_irq_d <= s_irq;
      pending <= pending_nxt;
      ipl_q   <= ipl_nxt;
    end
  end

endmodule

// File: tb/tb_nexi_intc_wb.sv
// tb/tb_nexi_intc_wb.sv - self-checking bench for nexi_intc_wb with a behavioural model
module tb_nexi_intc_wb;

  localparam int         NS    = 7;
  localparam logic [6:0] RMODE = 7'h00;
`ifdef NEXI_INTC_SOFT_IRQ_EN
  localparam bit SOFT_EN = 1'b1;
`else
  localparam bit SOFT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc;
  logic          stb;
  logic          we;
  logic [4:0]    addr;
  logic [31:0]   wdata;
  logic [3:0]    sel;
  logic [31:0]   data_o;
  logic          ack_o;
  logic [NS-1:0] irq;
  logic [2:0]    ipl_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  nexi_intc_wb #(
    .NUM_SRC    (NS),
    .RESET_MODE (RMODE)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .cyc_i  (cyc),
    .stb_i  (stb),
    .we_i   (we),
    .addr_i (addr),
    .data_i (wdata),
    .sel_i  (sel),
    .data_o (data_o),
    .ack_o  (ack_o),
    .irq_i  (irq),
    .ipl_o  (ipl_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0]  m_pend, m_en, m_mode;
  logic [6:0]  h0, h1, h2;   // irq samples taken 1, 2 and 3 edges ago
  logic        m_ack;
  logic [31:0] m_data;
  logic [2:0]  m_ipl;

  wire       m_acc = cyc & stb & ~m_ack;
  wire       m_wr  = m_acc & we & sel[0];
  wire [2:0] m_reg = addr[4:2];

  function automatic logic [2:0] top_level(input logic [6:0] v);
    int lvl = 0;
    for (int i = 0; i < NS; i++) if (v[i]) lvl = i + 1;
    return lvl[2:0];
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] r);
    logic [31:0] v = 32'h0;
    case (r)
      3'd0: v = (32'(m_ipl) << 8) | 32'(m_pend & m_en);
      3'd1: v = 32'(m_pend);
      3'd2: v = 32'(m_en);
      3'd3: v = 32'(m_mode);
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic logic [6:0] model_pending();
    logic [6:0] np = '0;
    logic [6:0] clr = (m_wr && m_reg == 3'd1) ? wdata[6:0] : 7'h0;
    logic [6:0] sft = (SOFT_EN && m_wr && m_reg == 3'd4) ? wdata[6:0] : 7'h0;
    for (int i = 0; i < NS; i++) begin
      if (m_mode[i])
        np[i] = (m_pend[i] && !clr[i]) || (h1[i] && !h2[i]) || sft[i];
      else
        np[i] = h1[i] || sft[i];
    end
    return np;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pend <= '0; m_en <= '0; m_mode <= RMODE;
      h0 <= '0; h1 <= '0; h2 <= '0;
      m_ack <= 1'b0; m_data <= '0; m_ipl <= '0;
    end else begin
      m_pend <= model_pending();
      m_ipl  <= top_level(m_pend & m_en);
      if (m_wr && m_reg == 3'd2) m_en   <= wdata[6:0];
      if (m_wr && m_reg == 3'd3) m_mode <= wdata[6:0];
      h0 <= irq; h1 <= h0; h2 <= h1;
      m_ack  <= m_acc;
      m_data <= m_acc ? model_read(m_reg) : 32'h0;
    end
  end

  // Every cycle: level, ack and (on ack) read data against the model
  always @(negedge clk) begin
    if (mon_en) begin
      check("ipl_model", ipl_o, m_ipl);
      check("ack_model", ack_o, m_ack);
      if (m_ack) check("data_model", data_o, m_data);
    end
  end

  // ---------------- bus helpers (called at a negedge) ----------------
  task automatic wb(input logic w, input logic [4:0] a, input logic [31:0] d,
                    input logic [3:0] s, output logic [31:0] rd);
    int lat = 0;
    if (ack_o) @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (ack_o) break;
    end
    rd = data_o;
    check("ack_latency", lat, 1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb(1'b1, a, d, 4'hF, dummy);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    wb(1'b0, a, 32'h0, 4'hF, d);
  endtask

  logic [31:0] v;

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; sel = '0; irq = '0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    rst = 1'b0;

    // Reset state of every register
    check("rst_ipl", ipl_o, 0);
    for (int r = 0; r < 8; r++) begin
      rd(5'(r * 4), v);
      check($sformatf("rst_reg%0d", r), v, (r == 3) ? 32'(RMODE) : 32'h0);
    end

    // Edge-mode latency
    wr(5'h08, 32'h7F);
    wr(5'h0C, 32'h7F);
    irq = 7'h04;
    @(negedge clk);
    irq = 7'h00;
    @(negedge clk);
    @(negedge clk);
    check("edge_ipl_c3", ipl_o, 0);
    @(negedge clk);
    check("edge_ipl_c4", ipl_o, 3);
    rd(5'h04, v);
    check("edge_pending", v, 32'h04);
    wr(5'h04, 32'h04);
    @(negedge clk);
    @(negedge clk);
    check("edge_w1c_ipl", ipl_o, 0);

    // Priority among edge sources
    irq = 7'h21;
    @(negedge clk);
    irq = 7'h00;
    repeat (4) @(negedge clk);
    check("prio_ipl6", ipl_o, 6);
    wr(5'h04, 32'h20);
    repeat (2) @(negedge clk);
    check("prio_ipl1", ipl_o, 1);
    wr(5'h08, 32'h7E);
    repeat (2) @(negedge clk);
    check("prio_dis_ipl", ipl_o, 0);
    rd(5'h04, v);
    check("prio_pend_kept", v, 32'h01);
    wr(5'h04, 32'h01);

    // Level mode ignores W1C and tracks the input
    wr(5'h0C, 32'h00);
    wr(5'h08, 32'h01);
    irq = 7'h01;
    repeat (4) @(negedge clk);
    wr(5'h04, 32'h01);
    rd(5'h04, v);
    check("lvl_pend", v, 32'h01);
    check("lvl_ipl", ipl_o, 1);
    irq = 7'h00;
    repeat (3) @(negedge clk);
    check("lvl_drop_c3", ipl_o, 1);
    @(negedge clk);
    check("lvl_drop_c4", ipl_o, 0);

    // Edge-set and W1C on the same edge: set wins
    wr(5'h0C, 32'h7F);
    wr(5'h08, 32'h7F);
    irq = 7'h02;
    @(negedge clk);
    @(negedge clk);
    wr(5'h04, 32'h02);
    rd(5'h04, v);
    check("collide_pend", v, 32'h02);
    irq = 7'h00;
    wr(5'h04, 32'h02);
    rd(5'h04, v);
    check("collide_clear", v, 32'h00);

    // Lane 0 disabled: write acked but ignored
    wb(1'b1, 5'h08, 32'h00, 4'b1110, v);
    rd(5'h08, v);
    check("sel_enable", v, 32'h7F);

    // Software interrupt
    wr(5'h10, 32'h40);
    wr(5'h08, 32'h40);
    wr(5'h0C, 32'h40);
    repeat (2) @(negedge clk);
    check("soft_ipl", ipl_o, SOFT_EN ? 32'd7 : 32'd0);
    rd(5'h04, v);
    check("soft_pend", v, SOFT_EN ? 32'h40 : 32'h00);
    rd(5'h10, v);
    check("soft_read", v, 32'h0);

    // Reset during an open cycle drops it
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 5'h08; wdata = 32'h55; sel = 4'hF;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ack", ack_o, 0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    rd(5'h08, v);
    check("rst_mid_enable", v, 32'h0);

    // Randomized traffic against the model
    for (int t = 0; t < 300; t++) begin
      irq = 7'($urandom_range(0, 127));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7) * 4), $urandom,
         ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15)), v);
    end
    irq = '0;
    repeat (6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
